// File: rtl/mux_out_pipe_if.sv
// rtl/mux_out_pipe_if.sv - handshake and result bus for mux_out_pipe
interface mux_out_pipe_if #(
  parameter int N     = 16,
  parameter int CW    = 6,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     sum;
  logic             co;
  logic [CW-1:0]    com_res;
  logic [1:0]       sel;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     sel_res;
  logic             sel_co;
  logic [CNT_W-1:0] acc_cnt;

  modport master (
    output in_valid, sum, co, com_res, sel, out_ready,
    input  in_ready, out_valid, sel_res, sel_co, acc_cnt
  );

  modport slave (
    input  in_valid, sum, co, com_res, sel, out_ready,
    output in_ready, out_valid, sel_res, sel_co, acc_cnt
  );
endinterface

// File: rtl/mux_out_pipe.sv
// rtl/mux_out_pipe.sv - result mode mux feeding a 2-entry skid FIFO with accept counter
module mux_out_pipe #(
  parameter int N     = 16,
  parameter int CW    = 6,
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  mux_out_pipe_if.slave  bus
);
  logic [1:0]       count;
  logic             rd_ptr;
  logic             wr_ptr;
  logic [N-1:0]     res_mem [2];
  logic [1:0]       co_mem;
  logic [CNT_W-1:0] acc_cnt_q;
  logic             accept;
  logic             pop;
  logic [N-1:0]     new_res;
  logic             new_co;

  // Ready depends only on registered occupancy, never on out_ready.
  assign bus.in_ready  = (count != 2'd2);
  assign bus.out_valid = (count != 2'd0);
  assign accept        = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  always_comb begin
    new_res = bus.sum;
    new_co  = bus.co;
    case (bus.sel)
      2'b00: begin
        new_res = bus.sum;
        new_co  = bus.co;
      end
      2'b01: begin
        new_res = {bus.sum[N-1:CW], bus.com_res};
        new_co  = bus.co;
      end
      2'b10: begin
        new_res = {{(N-CW){1'b0}}, bus.com_res};
        new_co  = 1'b0;
      end
      default: begin
        new_res = bus.co ? {N{1'b1}} : bus.sum;
        new_co  = bus.co;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= 2'd0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      res_mem[0] <= '0;
      res_mem[1] <= '0;
      co_mem     <= 2'b00;
      acc_cnt_q  <= '0;
    end else begin
      if (accept) begin
        res_mem[wr_ptr] <= new_res;
        co_mem[wr_ptr]  <= new_co;
        wr_ptr          <= ~wr_ptr;
        acc_cnt_q       <= acc_cnt_q + 1'b1;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({accept, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Empty buffer reads as zero rather than exposing stale entries.
  assign bus.sel_res = bus.out_valid ? res_mem[rd_ptr] : '0;
  assign bus.sel_co  = bus.out_valid ? co_mem[rd_ptr] : 1'b0;
  assign bus.acc_cnt = acc_cnt_q;
endmodule

// File: doc/mux_out_pipe.md
MUX_OUT_PIPE -- requirements
Module: mux_out_pipe

Parameters
REQ-001 The block SHALL have parameter N, default 16, meaning datapath width of sum/sel_res.
REQ-002 The block SHALL have parameter CW, default 6, meaning compare-result width, legal range 1..N-1.
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning width of the accepted-transaction counter.

Interface
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 in_valid  input  1  upstream presents a transaction.
REQ-008 in_ready  output  1  block can accept; high while buffer holds fewer than 2 entries.
REQ-009 sum  input  N  adder sum.
REQ-010 co  input  1  adder carry-out.
REQ-011 com_res  input  CW  comparator result.
REQ-012 sel  input  2  mode, sampled with the transaction.
REQ-013 out_valid  output  1  buffer head is valid.
REQ-014 out_ready  input  1  downstream accepts the head.
REQ-015 sel_res  output  N  selected result of the head entry.
REQ-016 sel_co  output  1  selected carry of the head entry.
REQ-017 acc_cnt  output  CNT_W  count of accepted input transactions, wraps modulo 2^CNT_W.

Function
REQ-018 Accept SHALL occur on a clock edge when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-019 Mode 00 SHALL compute sel_res=sum, sel_co=co.
REQ-020 Mode 01 SHALL compute sel_res[CW-1:0]=com_res, sel_res[N-1:CW]=sum[N-1:CW], sel_co=co.
REQ-021 Mode 10 SHALL compute sel_res=com_res zero-extended to N, sel_co=0.
REQ-022 Mode 11 SHALL saturate: co=1 gives sel_res all ones, sel_co=1; co=0 gives sel_res=sum, sel_co=0.
REQ-023 The result SHALL be computed at accept time and stored; later changes to sum/co/com_res/sel SHALL NOT alter stored entries.
REQ-024 Storage SHALL be a 2-entry FIFO (skid buffer) with count 0..2; in_ready SHALL equal (count!=2), decoded from registered count only, with no combinational path from out_ready.
REQ-025 Latency SHALL be 1 cycle: an entry accepted at edge t into an empty buffer SHALL be presented with out_valid=1 after edge t.
REQ-026 On simultaneous accept and pop, count SHALL be unchanged and order SHALL be preserved (FIFO).
REQ-027 With count=2 and pop, in_ready SHALL rise after that edge; no accept is possible on that edge.
REQ-028 out_valid SHALL equal (count!=0); sel_res/sel_co SHALL reflect the head entry and hold stable while out_valid && !out_ready.
REQ-029 When count=0, sel_res and sel_co SHALL read 0.
REQ-030 acc_cnt SHALL increment by 1 on every accept and wrap from 2^CNT_W-1 to 0.
REQ-031 in_valid while in_ready=0 SHALL be ignored, with no state change.

Reset
REQ-032 Asserting rst SHALL immediately, without waiting for a clock, clear count, both entries, and acc_cnt, giving out_valid=0, sel_res=0, sel_co=0, acc_cnt=0, in_ready=1.
REQ-033 Reset mid-operation SHALL discard all buffered entries; the first accept after deassertion SHALL behave as if into an empty buffer.

Verification
REQ-034 The bench SHALL cover mode sweep: N=16, CW=6, sum=16'hABCD, com_res=6'h15, co=1, out_ready=1. Required responses: sel 00 -> ABCD/1; sel 01 -> ABD5/1; sel 10 -> 0015/0; sel 11 -> FFFF/1.
REQ-035 The bench SHALL cover backpressure: out_ready=0 while 3 back-to-back valids are driven. Required response: first two accepted, in_ready=0 after the 2nd accept, 3rd held. When out_ready=1, outputs appear in order, the 3rd is accepted one cycle after the first pop, and acc_cnt=3.
REQ-036 The bench SHALL cover streaming: in_valid=out_ready=1 for 10 cycles with incrementing sum in mode 00. Required response: one output per cycle, 1-cycle latency, count never exceeds 1.
REQ-037 The bench SHALL cover hold stability: head entry with out_ready=0 while inputs toggle every cycle. Required response: sel_res/sel_co unchanged until pop.
REQ-038 The bench SHALL cover async reset: rst pulsed between clock edges with 2 entries buffered. Required response: out_valid=0, acc_cnt=0, in_ready=1 before the next edge, and a subsequent accept appears 1 cycle later.
REQ-039 The bench SHALL cover counter wrap: CNT_W=4 with 17 accepts. Required response: acc_cnt=1.
